// File: rtl/ififo.sv
// Instruction FIFO between fetch and dispatch; 1-cycle latency, flush squashes all entries.
// Backpressure: fetch_ififo_ready = !full; IFIFO_BYPASS_EN adds a zero-latency empty-FIFO bypass.
package ififo_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } ififo_entry_t;
endpackage

module ififo
    import ififo_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int ENTRY_WIDTH = $bits(ififo_entry_t)
) (
    input  logic                     clk,
    input  logic                     rst_aH,
    input  logic                     fetch_ififo_valid,
    output logic                     fetch_ififo_ready,
    input  logic [ENTRY_WIDTH-1:0]   fetch_ififo_data,
    output logic                     ififo_dispatch_valid,
    input  logic                     ififo_dispatch_ready,
    output logic [ENTRY_WIDTH-1:0]   ififo_dispatch_data,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_WIDTH-1:0] storage [DEPTH];
    logic [AW:0]            head;
    logic [AW:0]            tail;
    logic                   empty;
    logic                   full;
    logic                   push;
    logic                   pop;
    logic                   wr_en;
    logic                   head_inc;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty             = (head == tail);
    assign full              = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
    assign fetch_ififo_ready = !full;

    always_comb begin
        ififo_dispatch_valid = !empty && !flush;
        ififo_dispatch_data  = storage[head[AW-1:0]];
`ifdef IFIFO_BYPASS_EN
        if (empty && fetch_ififo_valid && !flush) begin
            ififo_dispatch_valid = 1'b1;
            ififo_dispatch_data  = fetch_ififo_data;
        end
`endif
        push     = fetch_ififo_valid && fetch_ififo_ready && !flush;
        pop      = ififo_dispatch_valid && ififo_dispatch_ready;
        wr_en    = push;
        head_inc = pop;
`ifdef IFIFO_BYPASS_EN
        // A bypassed entry consumed this cycle never touches storage.
        if (empty && pop) begin
            wr_en    = 1'b0;
            head_inc = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst_aH) begin
            storage[tail[AW-1:0]] <= fetch_ififo_data;
        end
    end

    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr_en) begin
                tail <= tail + 1'b1;
            end
            if (head_inc) begin
                head <= head + 1'b1;
            end
            case ({wr_en, head_inc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_ififo.sv
// Directed bench for ififo at DEPTH=8: reset, ordering, full+pop, wrap, flush, async reset, bypass.
module tb_ififo;
    localparam int W = $bits(ififo_pkg::ififo_entry_t);

    logic         clk;
    logic         rst_aH;
    logic         fetch_ififo_valid;
    logic         fetch_ififo_ready;
    logic [W-1:0] fetch_ififo_data;
    logic         ififo_dispatch_valid;
    logic         ififo_dispatch_ready;
    logic [W-1:0] ififo_dispatch_data;
    logic         flush;
    logic [3:0]   count;

    int n_cmp = 0;
    int n_err = 0;

    ififo #(.DEPTH(8)) dut (
        .clk                  (clk),
        .rst_aH               (rst_aH),
        .fetch_ififo_valid    (fetch_ififo_valid),
        .fetch_ififo_ready    (fetch_ififo_ready),
        .fetch_ififo_data     (fetch_ififo_data),
        .ififo_dispatch_valid (ififo_dispatch_valid),
        .ififo_dispatch_ready (ififo_dispatch_ready),
        .ififo_dispatch_data  (ififo_dispatch_data),
        .flush                (flush),
        .count                (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are sampled 1-2 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_aH = 1'b1;
        fetch_ififo_valid = 1'b1;
        fetch_ififo_data = 64'h77;
        ififo_dispatch_ready = 1'b0;
        flush = 1'b0;
        tick();
        tick();
        #1;
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (ififo_dispatch_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", ififo_dispatch_valid); end
        n_cmp++; if (fetch_ififo_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", fetch_ififo_ready); end
        fetch_ififo_valid = 1'b0;
        rst_aH = 1'b0;
        tick();
        #1;
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_no_accept: got %0d want 0", count); end
    endtask

    task automatic test_ordering();
        ififo_dispatch_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fetch_ififo_valid = 1'b1;
            fetch_ififo_data = 64'h11 + 64'(i);
            #1;
            n_cmp++; if (fetch_ififo_ready !== 1'b1) begin n_err++; $display("FAIL order_ready[%0d]: got %b want 1", i, fetch_ififo_ready); end
            tick();
            if (i == 0) begin
                fetch_ififo_valid = 1'b0;
                #1;
                n_cmp++; if (ififo_dispatch_valid !== 1'b1 || ififo_dispatch_data !== 64'h11)
                    begin n_err++; $display("FAIL latency1: got v=%b d=%h want v=1 d=11", ififo_dispatch_valid, ififo_dispatch_data); end
            end
        end
        fetch_ififo_valid = 1'b0;
        #1;
        n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL order_full_count: got %0d want 8", count); end
        n_cmp++; if (fetch_ififo_ready !== 1'b0) begin n_err++; $display("FAIL order_full_ready: got %b want 0", fetch_ififo_ready); end
        ififo_dispatch_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_cmp++; if (ififo_dispatch_valid !== 1'b1 || ififo_dispatch_data !== 64'h11 + 64'(i))
                begin n_err++; $display("FAIL order_drain[%0d]: got v=%b d=%h want v=1 d=%h", i, ififo_dispatch_valid, ififo_dispatch_data, 64'h11 + 64'(i)); end
            tick();
        end
        ififo_dispatch_ready = 1'b0;
        #1;
        n_cmp++; if (count !== 4'd0 || ififo_dispatch_valid !== 1'b0)
            begin n_err++; $display("FAIL order_empty: got count=%0d v=%b want 0 0", count, ififo_dispatch_valid); end
    endtask

    task automatic test_full_pop();
        ififo_dispatch_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fetch_ififo_valid = 1'b1;
            fetch_ififo_data = 64'h21 + 64'(i);
            tick();
        end
        fetch_ififo_data = 64'h99;
        ififo_dispatch_ready = 1'b1;
        #1;
        n_cmp++; if (fetch_ififo_ready !== 1'b0) begin n_err++; $display("FAIL fullpop_ready: got %b want 0", fetch_ififo_ready); end
        tick();
        fetch_ififo_valid = 1'b0;
        #1;
        n_cmp++; if (count !== 4'd7) begin n_err++; $display("FAIL fullpop_count: got %0d want 7", count); end
        for (int i = 1; i < 8; i++) begin
            n_cmp++; if (ififo_dispatch_valid !== 1'b1 || ififo_dispatch_data !== 64'h21 + 64'(i))
                begin n_err++; $display("FAIL fullpop_drain[%0d]: got d=%h want %h", i, ififo_dispatch_data, 64'h21 + 64'(i)); end
            tick();
        end
        ififo_dispatch_ready = 1'b0;
        #1;
        n_cmp++; if (ififo_dispatch_valid !== 1'b0 || count !== 4'd0)
            begin n_err++; $display("FAIL fullpop_no_99: got v=%b count=%0d want 0 0", ififo_dispatch_valid, count); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 20; i++) begin
            fetch_ififo_valid = 1'b1;
            fetch_ififo_data = 64'h40 + 64'(i);
            ififo_dispatch_ready = (i != 0);
            #1;
            if (i != 0) begin
                n_cmp++; if (ififo_dispatch_valid !== 1'b1 || ififo_dispatch_data !== 64'h40 + 64'(i - 1) || count !== 4'd1)
                    begin n_err++; $display("FAIL wrap[%0d]: got v=%b d=%h c=%0d want 1 %h 1", i, ififo_dispatch_valid, ififo_dispatch_data, count, 64'h40 + 64'(i - 1)); end
            end
            tick();
        end
        fetch_ififo_valid = 1'b0;
        #1;
        n_cmp++; if (ififo_dispatch_data !== 64'h53 || count !== 4'd1)
            begin n_err++; $display("FAIL wrap_last: got d=%h c=%0d want 53 1", ififo_dispatch_data, count); end
        tick();
        ififo_dispatch_ready = 1'b0;
        #1;
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL wrap_empty: got %0d want 0", count); end
    endtask

    task automatic test_flush();
        ififo_dispatch_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fetch_ififo_valid = 1'b1;
            fetch_ififo_data = 64'h51 + 64'(i);
            tick();
        end
        #1;
        n_cmp++; if (count !== 4'd5) begin n_err++; $display("FAIL flush_pre: got %0d want 5", count); end
        fetch_ififo_data = 64'hEE;
        flush = 1'b1;
        #1;
        n_cmp++; if (ififo_dispatch_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid_same: got %b want 0", ififo_dispatch_valid); end
        tick();
        flush = 1'b0;
        fetch_ififo_valid = 1'b0;
        #1;
        n_cmp++; if (count !== 4'd0 || ififo_dispatch_valid !== 1'b0)
            begin n_err++; $display("FAIL flush_after: got c=%0d v=%b want 0 0", count, ififo_dispatch_valid); end
        fetch_ififo_valid = 1'b1;
        fetch_ififo_data = 64'h61;
        tick();
        fetch_ififo_valid = 1'b0;
        #1;
        n_cmp++; if (ififo_dispatch_data !== 64'h61 || count !== 4'd1)
            begin n_err++; $display("FAIL flush_dropped: got d=%h c=%0d want 61 1", ififo_dispatch_data, count); end
        ififo_dispatch_ready = 1'b1;
        tick();
        ififo_dispatch_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        ififo_dispatch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fetch_ififo_valid = 1'b1;
            fetch_ififo_data = 64'h71 + 64'(i);
            tick();
        end
        fetch_ififo_valid = 1'b0;
        #1;
        n_cmp++; if (count !== 4'd3) begin n_err++; $display("FAIL rstmid_pre: got %0d want 3", count); end
        rst_aH = 1'b1;
        #1;
        n_cmp++; if (count !== 4'd0 || ififo_dispatch_valid !== 1'b0 || fetch_ififo_ready !== 1'b1)
            begin n_err++; $display("FAIL rstmid_async: got c=%0d v=%b r=%b want 0 0 1", count, ififo_dispatch_valid, fetch_ififo_ready); end
        tick();
        rst_aH = 1'b0;
        tick();
    endtask

    task automatic test_bypass();
        fetch_ififo_valid = 1'b1;
        fetch_ififo_data = 64'hAB;
        ififo_dispatch_ready = 1'b1;
        #1;
`ifdef IFIFO_BYPASS_EN
        n_cmp++; if (ififo_dispatch_valid !== 1'b1 || ififo_dispatch_data !== 64'hAB)
            begin n_err++; $display("FAIL bypass_same: got v=%b d=%h want 1 ab", ififo_dispatch_valid, ififo_dispatch_data); end
        tick();
        fetch_ififo_valid = 1'b0;
        #1;
        n_cmp++; if (count !== 4'd0 || ififo_dispatch_valid !== 1'b0)
            begin n_err++; $display("FAIL bypass_after: got c=%0d v=%b want 0 0", count, ififo_dispatch_valid); end
`else
        n_cmp++; if (ififo_dispatch_valid !== 1'b0) begin n_err++; $display("FAIL nobypass_same: got %b want 0", ififo_dispatch_valid); end
        tick();
        fetch_ififo_valid = 1'b0;
        #1;
        n_cmp++; if (ififo_dispatch_valid !== 1'b1 || ififo_dispatch_data !== 64'hAB || count !== 4'd1)
            begin n_err++; $display("FAIL nobypass_next: got v=%b d=%h c=%0d want 1 ab 1", ififo_dispatch_valid, ififo_dispatch_data, count); end
        tick();
        #1;
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL nobypass_drain: got %0d want 0", count); end
`endif
        ififo_dispatch_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ordering();
        test_full_pop();
        test_wrap();
        test_flush();
        test_reset_mid();
        test_bypass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ififo.md
IFIFO -- requirements
Module: ififo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count (power of two, >= 2).
REQ-002 SHALL have parameter ENTRY_WIDTH, default $bits(ififo_entry_t), payload width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_aH  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port fetch_ififo_valid  input  1  fetch offers an entry.
REQ-006 SHALL have port fetch_ififo_ready  output  1  FIFO accepts an entry this cycle.
REQ-007 SHALL have port fetch_ififo_data  input  ENTRY_WIDTH  entry from fetch (ififo_entry_t).
REQ-008 SHALL have port ififo_dispatch_valid  output  1  head entry presented to dispatch.
REQ-009 SHALL have port ififo_dispatch_ready  input  1  dispatch consumes the head this cycle.
REQ-010 SHALL have port ififo_dispatch_data  output  ENTRY_WIDTH  head entry (ififo_entry_t).
REQ-011 SHALL have port flush  input  1  branch/load mispredict squash (OR of alu_br_mispred, ld_mispred).
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-013 SHALL define push = fetch_ififo_valid && fetch_ififo_ready && !flush, and pop = ififo_dispatch_valid && ififo_dispatch_ready.
REQ-014 SHALL keep circular storage with head/tail pointers of $clog2(DEPTH)+1 bits; index = low bits; MSB is the wrap bit.
REQ-015 SHALL report empty when pointers are fully equal, and full when the index bits are equal and the wrap bits differ.
REQ-016 SHALL drive fetch_ififo_ready = !full, with no dependence on ififo_dispatch_ready; when full, a same-cycle push is refused even if a pop occurs.
REQ-017 SHALL drive ififo_dispatch_valid = !empty && !flush.
REQ-018 SHALL drive ififo_dispatch_data combinationally from storage[head index].
REQ-019 SHALL, on push, write fetch_ififo_data to storage[tail index] and increment tail at the clock edge.
REQ-020 SHALL, on pop, increment head at the clock edge.
REQ-021 SHALL update count by +1 on push only, -1 on pop only, and 0 on simultaneous push and pop.
REQ-022 SHALL have latency 1: an entry pushed at edge N is visible on ififo_dispatch_valid/data in cycle N+1.
REQ-023 SHALL preserve strict FIFO order across pointer wrap-around.
REQ-024 SHALL make flush highest priority: at the next edge, head, tail and count go to 0; the push in the flush cycle is dropped and no pop is counted.
REQ-025 SHALL hold ififo_dispatch_data stable while ififo_dispatch_valid is high and ififo_dispatch_ready is low.
REQ-026 SHALL treat data in storage as don't-care when empty; ififo_dispatch_valid alone qualifies it.

Reset
REQ-027 SHALL, on rst_aH assertion (asynchronous, any cycle including mid-transfer), clear head, tail and count to 0.
REQ-028 SHALL, during reset, drive ififo_dispatch_valid = 0 and fetch_ififo_ready = 1 (empty); storage contents are not reset.
REQ-029 SHALL leave reset synchronously with the first rising clk edge after deassertion, with no entries accepted while rst_aH is high.

Configuration
REQ-030 SHALL, with IFIFO_BYPASS_EN defined, drive ififo_dispatch_valid = 1 and ififo_dispatch_data = fetch_ififo_data combinationally when empty and fetch_ififo_valid && !flush.
REQ-031 SHALL, under bypass, skip the storage write when such an entry is popped in the same cycle; pointers and count stay unchanged (zero latency).
REQ-032 SHALL, under bypass, enqueue the entry normally when ififo_dispatch_ready = 0.
REQ-033 SHALL, without IFIFO_BYPASS_EN, have no combinational path from fetch_ififo_* to ififo_dispatch_*; latency is exactly 1 (REQ-022).

Verification
REQ-034 SHALL cover ordering: DEPTH=8, push 0x11..0x18 back-to-back with dispatch_ready=0 -> count=8, fetch_ififo_ready=0; then drain -> 0x11..0x18 out in order, count returns 0.
REQ-035 SHALL cover wrap-around: 20 pushes with a concurrent pop every cycle after the first -> count stays 1, data order intact, head/tail wrap bits toggle.
REQ-036 SHALL cover full with concurrent pop: full FIFO, fetch_ififo_valid=1, dispatch_ready=1 -> one pop, no push, count=7 next cycle.
REQ-037 SHALL cover flush: count=5 plus push asserted and flush=1 -> next cycle count=0, ififo_dispatch_valid=0, dropped entry never appears.
REQ-038 SHALL cover reset mid-operation: count=3, assert rst_aH between edges -> valid=0, count=0 immediately, without waiting for a clock edge.
REQ-039 SHALL cover bypass: empty FIFO, push 0xAB with dispatch_ready=1 -> with IFIFO_BYPASS_EN, 0xAB is dispatched the same cycle and count stays 0; without it, 0xAB appears next cycle.
